// File: rtl/usr_param_shift_register.sv
// usr_param_shift_register: WIDTH-bit universal shift register with eight modes and a
// burst engine. One start command runs `count` steps of the latched mode and reports
// progress on busy/done.
// Optional feature macro: USR_ABORT_EN (adds abort input and aborted pulse output).
module usr_param_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] p_data,
    input  logic             s_in_r,
    input  logic             s_in_l,
`ifdef USR_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] q_parallel,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_mode;
    logic [2:0]       w_mode_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_sout;
`ifdef USR_ABORT_EN
    logic             r_aborted;
    logic             w_aborted_nxt;
`endif

    // Result of one step of the latched mode; hold, load and reserved keep s_out.
    always_comb begin
        w_step_q    = r_q;
        w_step_sout = r_sout;
        case (r_mode)
            3'b001: begin
                w_step_q    = {s_in_r, r_q[MSB:1]};
                w_step_sout = r_q[0];
            end
            3'b010: begin
                w_step_q    = {r_q[MSB-1:0], s_in_l};
                w_step_sout = r_q[MSB];
            end
            3'b011: begin
                w_step_q    = p_data;
            end
            3'b100: begin
                w_step_q    = {r_q[0], r_q[MSB:1]};
                w_step_sout = r_q[0];
            end
            3'b101: begin
                w_step_q    = {r_q[MSB-1:0], r_q[MSB]};
                w_step_sout = r_q[MSB];
            end
            3'b110: begin
                w_step_q    = {r_q[MSB], r_q[MSB:1]};
                w_step_sout = r_q[0];
            end
            default: begin
                w_step_q    = r_q;
                w_step_sout = r_sout;
            end
        endcase
    end

    // Burst control: next state, latched command, step application and handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef USR_ABORT_EN
        w_aborted_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_mode_nxt  = mode;
                        w_cnt_nxt   = count;
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        // Empty burst completes immediately without touching data.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
`ifdef USR_ABORT_EN
                if (abort) begin
                    // Abort wins over any step, including the final one.
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_aborted_nxt = 1'b1;
                end else begin
`endif
                    w_q_nxt    = w_step_q;
                    w_sout_nxt = w_step_sout;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
`ifdef USR_ABORT_EN
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef USR_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef USR_ABORT_EN
            r_aborted <= w_aborted_nxt;
`endif
        end
    end

    assign q_parallel = r_q;
    assign s_out      = r_sout;
    assign busy       = r_busy;
    assign done       = r_done;
`ifdef USR_ABORT_EN
    assign aborted    = r_aborted;
`endif

endmodule

// File: tb/tb_usr_param_shift_register.sv
// Self-checking bench for usr_param_shift_register (default build, WIDTH=8, CNT_W=4).
// Directed cases plus random bursts compared against an arithmetic reference model.
module tb_usr_param_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [2:0]    mode;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  p_data;
    logic          s_in_r;
    logic          s_in_l;
    logic [W-1:0]  q_parallel;
    logic          s_out;
    logic          busy;
    logic          done;

    usr_param_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .start      (start),
        .count      (count),
        .p_data     (p_data),
        .s_in_r     (s_in_r),
        .s_in_l     (s_in_l),
        .q_parallel (q_parallel),
        .s_out      (s_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] mq;
    logic         mso;

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, ".q"},    32'(q_parallel), 32'(mq));
        chk({tag, ".sout"}, 32'(s_out),      32'(mso));
        chk({tag, ".busy"}, 32'(busy),       32'(exp_busy));
        chk({tag, ".done"}, 32'(done),       32'(exp_done));
    endtask

    // Reference: one step described arithmetically.
    task automatic model_step(input logic [2:0] m, input logic sir, input logic sil,
                              input logic [W-1:0] pd);
        logic [W-1:0] top;
        logic         lo;
        logic         hi;
        top = W'(1) << (W - 1);
        lo  = (mq % 2) != 0;
        hi  = mq >= top;
        case (m)
            3'd1: begin mso = lo; mq = (mq >> 1) | (sir ? top : '0); end
            3'd2: begin mso = hi; mq = W'(mq * 2) + W'(sil); end
            3'd3: mq = pd;
            3'd4: begin mso = lo; mq = (mq >> 1) | (lo ? top : '0); end
            3'd5: begin mso = hi; mq = W'(mq * 2) + W'(hi); end
            3'd6: begin mso = lo; mq = (mq >> 1) | (hi ? top : '0); end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one burst from a negedge; returns at the negedge where done is high.
    task automatic run_burst(input logic [2:0] m, input int n, input bit rnd,
                             input logic [W-1:0] pd, input logic sir, input logic sil,
                             input bit hammer);
        logic         cur_sir;
        logic         cur_sil;
        logic [W-1:0] cur_pd;
        mode   = m;
        count  = CW'(n);
        start  = 1'b1;
        p_data = rnd ? W'($urandom) : pd;
        s_in_r = rnd ? 1'($urandom) : sir;
        s_in_l = rnd ? 1'($urandom) : sil;
        tick();
        if (n == 0) begin
            start = 1'b0;
            chk_all("zero_cnt", 1'b0, 1'b1);
            return;
        end
        chk_all("t0", 1'b1, 1'b0);
        for (int i = 1; i <= n; i++) begin
            cur_pd  = rnd ? W'($urandom) : pd;
            cur_sir = rnd ? 1'($urandom) : sir;
            cur_sil = rnd ? 1'($urandom) : sil;
            p_data  = cur_pd;
            s_in_r  = cur_sir;
            s_in_l  = cur_sil;
            start   = hammer ? 1'b1 : 1'($urandom);
            mode    = 3'($urandom);
            count   = CW'($urandom);
            tick();
            model_step(m, cur_sir, cur_sil, cur_pd);
            chk_all("step", i < n, i == n);
        end
        start = 1'b0;
    endtask

    task automatic idle(input int k);
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst    = 1'b0;
        mode   = '0;
        start  = 1'b0;
        count  = '0;
        p_data = '0;
        s_in_r = 1'b0;
        s_in_l = 1'b0;
        mq     = '0;
        mso    = 1'b0;

        // Asynchronous reset, asserted between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Load, then shift right with s_in_r=1.
        run_burst(3'b011, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load_a5", 32'(q_parallel), 32'h0000_00A5);
        run_burst(3'b001, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shr_f4", 32'(q_parallel), 32'h0000_00F4);
        chk("shr_sout", 32'(s_out), 32'd1);
        idle(1);

        // Rotate left and arithmetic shift right.
        run_burst(3'b011, 1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_burst(3'b101, 4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rol_c3", 32'(q_parallel), 32'h0000_00C3);
        run_burst(3'b011, 1, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0);
        run_burst(3'b110, 2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("asr_e4", 32'(q_parallel), 32'h0000_00E4);
        chk("asr_sout", 32'(s_out), 32'd0);

        // Zero-length burst, then a 5-step burst with start held high throughout.
        run_burst(3'b100, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_burst(3'b100, 5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset in the middle of a 10-step rotate.
        mode  = 3'b100;
        count = CW'(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            model_step(3'b100, 1'b0, 1'b0, '0);
        end
        chk_all("pre_rst", 1'b1, 1'b0);
        #2 rst = 1'b1;
        mq  = '0;
        mso = 1'b0;
        #1 chk_all("mid_rst", 1'b0, 1'b0);
        @(negedge clk);
        chk_all("rst_hold", 1'b0, 1'b0);
        rst = 1'b0;
        idle(3);
        run_burst(3'b011, 1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_rst_load", 32'(q_parallel), 32'h0000_005A);

        // Random bursts, many back-to-back off the done cycle.
        for (int k = 0; k < 60; k++) begin
            run_burst(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      1'b1, '0, 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
